// File: rtl/nes_cpu_pkg.sv
// -----------------------------------------------------------------------------
// nes_cpu_pkg
//   Shared types and constants for the NES 6502 core. This slice carries the
//   items used by the program-counter sequencer (pc_seq_ctrl):
//     vec_src_t       - which vector is being fetched / was accepted
//     pc_seq_state_t  - sequencer state
//     *_VEC_ADDR      - 6502 vector low-byte addresses (parameter defaults)
// -----------------------------------------------------------------------------
package nes_cpu_pkg;

  typedef enum logic [1:0] {
    VEC_RST = 2'd0,
    VEC_NMI = 2'd1,
    VEC_IRQ = 2'd2
  } vec_src_t;

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    LOAD   = 2'd2,
    RUN    = 2'd3
  } pc_seq_state_t;

  localparam logic [15:0] NMI_VEC_ADDR = 16'hFFFA;
  localparam logic [15:0] RST_VEC_ADDR = 16'hFFFC;
  localparam logic [15:0] IRQ_VEC_ADDR = 16'hFFFE;

endpackage

// File: rtl/pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pc_seq_ctrl
//   Program-counter sequencer for the NES 6502 core. After reset, and after
//   every accepted NMI/IRQ, it reads the two-byte vector over the byte memory
//   port, loads it into the PC for one cycle, then lets the core run. While
//   running it forwards execute-stage branch loads to the PC unchanged and
//   accepts interrupts at instruction boundaries (NMI before IRQ).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mem_req_o           vector read request (VEC_LO / VEC_HI)
//   mem_addr_o          vector read address, stable until acknowledged
//   mem_rdata_i         read data, valid while mem_ack_i=1
//   mem_ack_i           read accepted
//   nmi_i               NMI line, rising-edge sensitive
//   irq_i, irq_mask_i   IRQ line (level) and processor I flag
//   instr_boundary_i    current instruction completes this cycle
//   branch_i            taken branch/jump this cycle
//   branch_target_i     branch target address
//   pc_load_o           PC load strobe (to pc_t)
//   pc_load_val_o       PC load value (to pc_t)
//   run_o               PC advance / fetch enable
//   int_ack_o           one-cycle interrupt-accepted pulse
//   int_src_o           vec_src_t of the accepted interrupt while int_ack_o=1
// -----------------------------------------------------------------------------
module pc_seq_ctrl
  import nes_cpu_pkg::*;
#(
  parameter int                ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] NMI_VEC = ADDR_W'(NMI_VEC_ADDR),
  parameter logic [ADDR_W-1:0] RST_VEC = ADDR_W'(RST_VEC_ADDR),
  parameter logic [ADDR_W-1:0] IRQ_VEC = ADDR_W'(IRQ_VEC_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_ack_i,
  input  logic              nmi_i,
  input  logic              irq_i,
  input  logic              irq_mask_i,
  input  logic              instr_boundary_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              pc_load_o,
  output logic [ADDR_W-1:0] pc_load_val_o,
  output logic              run_o,
  output logic              int_ack_o,
  output logic [1:0]        int_src_o
);

  pc_seq_state_t r_state;
  vec_src_t      r_vec_src;
  logic [7:0]    r_lo;
  logic [7:0]    r_hi;
  logic          r_nmi_pending;
  logic          r_nmi_q;

  logic [ADDR_W-1:0] w_vec_addr;
  logic              w_in_fetch;
  logic              w_nmi_rise;
  logic              w_irq_req;
  logic              w_accept;
  logic              w_take_nmi;
  vec_src_t          w_accept_src;

  // The vector base address is a pure function of the vector source, so the
  // source register doubles as the vector-address register.
  always_comb begin
    w_vec_addr = RST_VEC;
    case (r_vec_src)
      VEC_NMI: w_vec_addr = NMI_VEC;
      VEC_IRQ: w_vec_addr = IRQ_VEC;
      default: w_vec_addr = RST_VEC;
    endcase
  end

  assign w_in_fetch = (r_state == VEC_LO) || (r_state == VEC_HI);
  assign w_nmi_rise = nmi_i & ~r_nmi_q;
  assign w_irq_req  = irq_i & ~irq_mask_i;

  // A taken branch on the boundary cycle wins: the branch target must reach
  // the PC, so interrupt entry is deferred to the next boundary.
  assign w_accept     = (r_state == RUN) & instr_boundary_i & ~branch_i &
                        (r_nmi_pending | w_irq_req);
  assign w_take_nmi   = w_accept & r_nmi_pending;
  assign w_accept_src = r_nmi_pending ? VEC_NMI : VEC_IRQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= VEC_LO;
      r_vec_src     <= VEC_RST;
      r_lo          <= 8'h00;
      r_hi          <= 8'h00;
      r_nmi_pending <= 1'b0;
      r_nmi_q       <= 1'b0;
    end else begin
      r_nmi_q <= nmi_i;
      // A fresh edge in the same cycle as NMI acceptance must not be lost,
      // so the set term dominates the clear.
      r_nmi_pending <= w_nmi_rise | (r_nmi_pending & ~w_take_nmi);

      case (r_state)
        VEC_LO: begin
          if (mem_ack_i) begin
            r_lo    <= mem_rdata_i;
            r_state <= VEC_HI;
          end
        end
        VEC_HI: begin
          if (mem_ack_i) begin
            r_hi    <= mem_rdata_i;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_state <= RUN;
        end
        RUN: begin
          if (w_accept) begin
            r_vec_src <= w_accept_src;
            r_state   <= VEC_LO;
          end
        end
        default: begin
          r_state <= VEC_LO;
        end
      endcase
    end
  end

  // mem_req_o is masked by rst because the reset state is VEC_LO, yet no
  // request may be presented while reset is held.
  always_comb begin
    mem_req_o     = w_in_fetch & ~rst;
    mem_addr_o    = (r_state == VEC_HI) ? (w_vec_addr + ADDR_W'(1)) : w_vec_addr;
    pc_load_o     = 1'b0;
    pc_load_val_o = '0;
    run_o         = (r_state == RUN);
    int_ack_o     = w_accept;
    int_src_o     = w_accept ? w_accept_src : VEC_RST;

    case (r_state)
      LOAD: begin
        pc_load_o     = 1'b1;
        pc_load_val_o = ADDR_W'({r_hi, r_lo});
      end
      RUN: begin
        // Zero-latency pass-through of the execute-stage branch.
        pc_load_o     = branch_i;
        pc_load_val_o = branch_target_i;
      end
      default: begin
        pc_load_o     = 1'b0;
        pc_load_val_o = '0;
      end
    endcase
  end

endmodule
